// File: rtl/map_table_pkg.sv
// ============================================================================
// Module      : map_table_pkg
// Description : Shared rename-stage constants and bus types for map_table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package map_table_pkg;

    localparam int LRF_NUM   = 32;
    localparam int PRF_NUM   = 64;
    localparam int LRF_IDX_W = 5;
    localparam int PRF_IDX_W = 6;

    localparam logic [PRF_IDX_W-1:0] ZERO_REG = '0;

    localparam int BR_STATE_W = 2;
    localparam logic [BR_STATE_W-1:0] BR_NONE       = 2'd0;
    localparam logic [BR_STATE_W-1:0] BR_PR_CORRECT = 2'd1;
    localparam logic [BR_STATE_W-1:0] BR_PR_WRONG   = 2'd2;

    // Entry i occupies bits [i*PRF_IDX_W +: PRF_IDX_W] of the flattened bus.
    typedef logic [LRF_NUM-1:0][PRF_IDX_W-1:0] map_t;

    // Logical reg i maps to preg i; the free list starts at preg LRF_NUM.
    function automatic map_t identity_map();
        map_t m;
        for (int i = 0; i < LRF_NUM; i++) begin
            m[i] = PRF_IDX_W'(i);
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/map_table_if.sv
// ============================================================================
// Module      : map_table_if
// Description : Dispatch / CDB / recovery bundle between pipeline and map_table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface map_table_if;
    import map_table_pkg::*;

    logic                  dispatch_en_i;
    logic [LRF_IDX_W-1:0]  rs1_idx_i;
    logic [LRF_IDX_W-1:0]  rs2_idx_i;
    logic [LRF_IDX_W-1:0]  rd_idx_i;
    logic                  rd_vld_i;
    logic [PRF_IDX_W-1:0]  free_preg_i;
    logic                  cdb_vld_i;
    logic [PRF_IDX_W-1:0]  cdb_tag_i;
    logic [BR_STATE_W-1:0] branch_state_i;
    map_t                  rc_map_i;

    logic [PRF_IDX_W-1:0]  rs1_preg_o;
    logic                  rs1_rdy_o;
    logic [PRF_IDX_W-1:0]  rs2_preg_o;
    logic                  rs2_rdy_o;
    logic [PRF_IDX_W-1:0]  told_o;
    map_t                  map_snapshot_o;

    modport master (
        output dispatch_en_i, rs1_idx_i, rs2_idx_i, rd_idx_i, rd_vld_i,
               free_preg_i, cdb_vld_i, cdb_tag_i, branch_state_i, rc_map_i,
        input  rs1_preg_o, rs1_rdy_o, rs2_preg_o, rs2_rdy_o, told_o,
               map_snapshot_o
    );

    modport slave (
        input  dispatch_en_i, rs1_idx_i, rs2_idx_i, rd_idx_i, rd_vld_i,
               free_preg_i, cdb_vld_i, cdb_tag_i, branch_state_i, rc_map_i,
        output rs1_preg_o, rs1_rdy_o, rs2_preg_o, rs2_rdy_o, told_o,
               map_snapshot_o
    );

endinterface

`default_nettype wire

// File: rtl/map_table_preg_rdy_tbl.sv
// ============================================================================
// Module      : preg_rdy_tbl
// Description : Per-preg ready bits with one clear, one set and two read ports.
//               MT_CDB_BYPASS_EN forwards a same-cycle set to the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module preg_rdy_tbl
    import map_table_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 clr_en,
    input  wire logic [PRF_IDX_W-1:0] clr_idx,
    input  wire logic                 set_en,
    input  wire logic [PRF_IDX_W-1:0] set_idx,
    input  wire logic [PRF_IDX_W-1:0] rd0_idx,
    output logic                      rd0_rdy,
    input  wire logic [PRF_IDX_W-1:0] rd1_idx,
    output logic                      rd1_rdy
);

    logic [PRF_NUM-1:0] r_rdy;
    logic               w_rd0_byp;
    logic               w_rd1_byp;

    // Preg 0 is never touched so it reads as permanently ready.
    // The clear is written last so an allocation beats a same-cycle broadcast.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdy <= '1;
        end else begin
            if (set_en && (set_idx != ZERO_REG)) begin
                r_rdy[set_idx] <= 1'b1;
            end
            if (clr_en && (clr_idx != ZERO_REG)) begin
                r_rdy[clr_idx] <= 1'b0;
            end
        end
    end

`ifdef MT_CDB_BYPASS_EN
    assign w_rd0_byp = set_en && (set_idx == rd0_idx);
    assign w_rd1_byp = set_en && (set_idx == rd1_idx);
`else
    assign w_rd0_byp = 1'b0;
    assign w_rd1_byp = 1'b0;
`endif

    assign rd0_rdy = r_rdy[rd0_idx] | w_rd0_byp;
    assign rd1_rdy = r_rdy[rd1_idx] | w_rd1_byp;

    a_no_alloc_cdb_collision: assert property (
        @(posedge clk) disable iff (rst)
        !(clr_en && set_en && (clr_idx == set_idx) && (clr_idx != ZERO_REG))
    );

endmodule

`default_nettype wire

// File: rtl/map_table.sv
// ============================================================================
// Module      : map_table
// Description : Register-rename map table: source lookup, rd remap with Told,
//               snapshot export and checkpoint restore. Optional macro
//               MT_CDB_BYPASS_EN adds same-cycle CDB forwarding to ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module map_table
    import map_table_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    map_table_if.slave  bus
);

    map_t r_map;
    logic w_recover;
    logic w_rename_we;

    assign w_recover   = (bus.branch_state_i == BR_PR_WRONG);
    assign w_rename_we = bus.dispatch_en_i && bus.rd_vld_i &&
                         (bus.rd_idx_i != '0) && !w_recover;

    // Recovery overrides any same-cycle rename; r0 is pinned to ZERO_REG
    // even if the checkpoint carries something else there.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_map <= identity_map();
        end else if (w_recover) begin
            r_map    <= bus.rc_map_i;
            r_map[0] <= ZERO_REG;
        end else if (w_rename_we) begin
            r_map[bus.rd_idx_i] <= bus.free_preg_i;
        end
    end

    assign bus.rs1_preg_o     = r_map[bus.rs1_idx_i];
    assign bus.rs2_preg_o     = r_map[bus.rs2_idx_i];
    assign bus.told_o         = bus.rd_vld_i ? r_map[bus.rd_idx_i] : ZERO_REG;
    assign bus.map_snapshot_o = r_map;

    preg_rdy_tbl u_rdy_tbl (
        .clk     (clk),
        .rst     (rst),
        .clr_en  (w_rename_we),
        .clr_idx (bus.free_preg_i),
        .set_en  (bus.cdb_vld_i),
        .set_idx (bus.cdb_tag_i),
        .rd0_idx (bus.rs1_preg_o),
        .rd0_rdy (bus.rs1_rdy_o),
        .rd1_idx (bus.rs2_preg_o),
        .rd1_rdy (bus.rs2_rdy_o)
    );

endmodule

`default_nettype wire
